// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// control state and a small sign helper used by the divider datapath.
package mul_div_unit_pkg;

  localparam int unsigned MDUOP_SIZE = 3;

  typedef enum logic [MDUOP_SIZE-1:0] {
    MDUOP_NONE  = 3'd0,
    MDUOP_MULT  = 3'd1,
    MDUOP_MULTU = 3'd2,
    MDUOP_DIV   = 3'd3,
    MDUOP_DIVU  = 3'd4,
    MDUOP_MTHI  = 3'd5,
    MDUOP_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } mdu_state_e;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at accept time and held back until the latency expires.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MDUOP_SIZE-1:0] operation,
  input  logic [31:0]           operand1,
  input  logic [31:0]           operand2,
  output logic                  busy,
  output logic [31:0]           hi,
  output logic [31:0]           lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [63:0]      pend_q, pend_d;
  logic             pend_we_q, pend_we_d;

  logic [63:0] prod_s, prod_u;
  logic        is_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    prod_u    = {32'b0, operand1} * {32'b0, operand2};
    prod_s    = {{32{operand1[31]}}, operand1} * {{32{operand2[31]}}, operand2};
    // Divide on magnitudes so 0x80000000 / -1 needs no special case.
    is_signed = (operation == MDUOP_DIV);
    a_neg     = is_signed & operand1[31];
    b_neg     = is_signed & operand2[31];
    a_mag     = neg_if(a_neg, operand1);
    b_mag     = neg_if(b_neg, operand2);
    b_safe    = (operand2 == '0) ? 32'd1 : b_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    quot      = neg_if(a_neg ^ b_neg, q_mag);
    rem       = neg_if(a_neg, r_mag);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_d    = pend_q;
    pend_we_d = pend_we_q;
    if (state_q == ST_BUSY) begin
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (pend_we_q) begin
          hi_d = pend_q[63:32];
          lo_d = pend_q[31:0];
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (start) begin
      case (operation)
        MDUOP_MULT, MDUOP_MULTU: begin
          pend_d    = (operation == MDUOP_MULT) ? prod_s : prod_u;
          pend_we_d = 1'b1;
          cnt_d     = CNT_W'(MULT_CYCLES);
          state_d   = ST_BUSY;
        end
        MDUOP_DIV, MDUOP_DIVU: begin
          pend_d    = {rem, quot};
          pend_we_d = (operand2 != '0);
          cnt_d     = CNT_W'(DIV_CYCLES);
          state_d   = ST_BUSY;
        end
        MDUOP_MTHI: hi_d = operand1;
        MDUOP_MTLO: lo_d = operand1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_q    <= pend_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes reference results,
// a negedge monitor pops them whenever a busy window closes.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [MDUOP_SIZE-1:0] operation = MDUOP_NONE;
  logic [31:0]           operand1 = '0;
  logic [31:0]           operand2 = '0;
  logic                  busy;
  logic [31:0]           hi;
  logic [31:0]           lo;

  always #5 clk = ~clk;

  mul_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .operand1(operand1), .operand2(operand2), .busy(busy), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cycles;
    string       name;
  } exp_t;

  exp_t        expq[$];
  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [31:0] mdl_hi  = '0;
  logic [31:0] mdl_lo  = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    longint          sp, sq, sr;
    longint unsigned up, uq, ur;
    case (op)
      MDUOP_MULT: begin
        sp = sa * sb;
        mdl_hi = sp[63:32]; mdl_lo = sp[31:0];
        expq.push_back('{hi: mdl_hi, lo: mdl_lo, cycles: MULT_N, name: "mult"});
      end
      MDUOP_MULTU: begin
        up = ua * ub;
        mdl_hi = up[63:32]; mdl_lo = up[31:0];
        expq.push_back('{hi: mdl_hi, lo: mdl_lo, cycles: MULT_N, name: "multu"});
      end
      MDUOP_DIV: begin
        if (b != 0) begin
          sq = sa / sb; sr = sa % sb;
          mdl_hi = sr[31:0]; mdl_lo = sq[31:0];
        end
        expq.push_back('{hi: mdl_hi, lo: mdl_lo, cycles: DIV_N, name: "div"});
      end
      MDUOP_DIVU: begin
        if (b != 0) begin
          uq = ua / ub; ur = ua % ub;
          mdl_hi = ur[31:0]; mdl_lo = uq[31:0];
        end
        expq.push_back('{hi: mdl_hi, lo: mdl_lo, cycles: DIV_N, name: "divu"});
      end
      MDUOP_MTHI: mdl_hi = a;
      MDUOP_MTLO: mdl_lo = a;
      default: ;
    endcase
  endfunction

  // Monitor: measures each busy window and checks the committed result.
  int unsigned run = 0;
  bit          aborted = 1'b0;
  bit          stable;
  logic [31:0] snap_hi, snap_lo;
  exp_t        e;

  always @(negedge clk) begin
    if (reset) begin
      if (run > 0) aborted = 1'b1;
    end else if (busy) begin
      if (run == 0) begin
        snap_hi = hi; snap_lo = lo; stable = 1'b1;
      end else if (hi !== snap_hi || lo !== snap_lo) begin
        stable = 1'b0;
      end
      run++;
    end else if (run > 0) begin
      if (aborted) begin
        expq.delete();
      end else if (expq.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_completion: got busy run %0d expected none", run);
      end else begin
        e = expq.pop_front();
        check32({e.name, "_hi"}, hi, e.hi);
        check32({e.name, "_lo"}, lo, e.lo);
        check32({e.name, "_busy_cycles"}, 32'(run), 32'(e.cycles));
        check32({e.name, "_hilo_stable"}, {31'b0, stable}, 32'd1);
      end
      run = 0;
      aborted = 1'b0;
    end
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    operation = op; operand1 = a; operand2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; operation = MDUOP_NONE; operand1 = $urandom; operand2 = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        @(posedge clk); #1;
        return;
      end
    end
    vectors++; errors++;
    $display("FAIL busy_timeout: got busy=1 after 40 cycles expected busy=0");
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    model(op, a, b);
    drive(op, a, b);
    wait_idle();
    if (!(op inside {MDUOP_MULT, MDUOP_MULTU, MDUOP_DIV, MDUOP_DIVU})) begin
      check32("direct_hi", hi, mdl_hi);
      check32("direct_lo", lo, mdl_lo);
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check32("reset_busy", {31'b0, busy}, 32'd0);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);

    issue(MDUOP_MULT,  32'hFFFF_FFFE, 32'd3);
    issue(MDUOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(MDUOP_DIV,   32'hFFFF_FFF9, 32'd2);
    issue(MDUOP_DIVU,  32'd7, 32'd2);
    issue(MDUOP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);

    // Back-to-back MTHI/MTLO, then divide by zero.
    model(MDUOP_MTHI, 32'h1234_5678, 32'd0);
    drive(MDUOP_MTHI, 32'h1234_5678, 32'd0);
    check32("mthi_busy", {31'b0, busy}, 32'd0);
    check32("mthi_hi", hi, 32'h1234_5678);
    model(MDUOP_MTLO, 32'hCAFE_BABE, 32'd0);
    drive(MDUOP_MTLO, 32'hCAFE_BABE, 32'd0);
    check32("mtlo_busy", {31'b0, busy}, 32'd0);
    check32("mtlo_hi", hi, 32'h1234_5678);
    check32("mtlo_lo", lo, 32'hCAFE_BABE);
    issue(MDUOP_DIV, 32'd5, 32'd0);

    // Start while busy must be ignored.
    model(MDUOP_MULT, 32'd1000, 32'hFFFF_FFF0);
    drive(MDUOP_MULT, 32'd1000, 32'hFFFF_FFF0);
    @(posedge clk); #1;
    drive(MDUOP_DIVU, 32'd99, 32'd4);
    wait_idle();

    // Reset mid-divide discards the operation.
    model(MDUOP_DIV, 32'd100, 32'd3);
    drive(MDUOP_DIV, 32'd100, 32'd3);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_hi = '0; mdl_lo = '0;
    check32("abort_busy", {31'b0, busy}, 32'd0);
    check32("abort_hi", hi, 32'd0);
    check32("abort_lo", lo, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check32("abort_later_busy", {31'b0, busy}, 32'd0);
    check32("abort_later_hi", hi, 32'd0);
    check32("abort_later_lo", lo, 32'd0);

    for (int n = 0; n < 60; n++) begin
      issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
    end

    repeat (3) @(posedge clk);
    #1;
    check32("queue_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
